// File: rtl/fifo_flex_pkg.sv
// rtl/fifo_flex_pkg.sv - shared router FIFO constants and width helpers
package fifo_flex_pkg;

  localparam int FIFO_WIDTH_DFLT = 32;
  localparam int FIFO_DEPTH_DFLT = 16;
  localparam int FIFO_AE_DFLT    = 2;
  localparam int FIFO_FWFT_DFLT  = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Occupancy needs one extra bit so that count == DEPTH is representable.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// rtl/fifo_flex_mem.sv - simple dual-port RAM, synchronous write, asynchronous read
module fifo_flex_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised synchronous FIFO with occupancy, thresholds and error pulses
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DFLT,
  parameter int DEPTH     = FIFO_DEPTH_DFLT,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = FIFO_AE_DFLT,
  parameter int FWFT      = FIFO_FWFT_DFLT
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_din,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [WIDTH-1:0] w_rd_data;

  // Flags depend on the count register alone so acceptance uses pre-edge state.
  assign w_full         = (r_count == FULL_CNT);
  assign w_empty        = (r_count == '0);
  assign w_push_ok      = i_push && !w_full;
  assign w_pop_ok       = i_pop && !w_empty;

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= AF_CNT);
  assign o_almost_empty = (r_count <= AE_CNT);
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  fifo_flex_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clock (i_clock),
    .i_we    (w_push_ok && !i_reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= i_push && w_full;
      r_underflow <= i_pop && w_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_dout = w_empty ? '0 : w_rd_data;
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge i_clock) begin
        if (i_reset)       r_dout <= '0;
        else if (w_pop_ok) r_dout <= w_rd_data;
      end
      assign o_dout = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - self-checking bench for fifo_flex, registered and FWFT builds
module tb_fifo_flex;

  localparam int D0 = 16;
  localparam int D1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_push, a_pop;
  logic [31:0] a_din, a_dout;
  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0]  a_count;

  logic        b_reset, b_push, b_pop;
  logic [31:0] b_din, b_dout;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_count;

  fifo_flex #(.WIDTH(32), .DEPTH(D0), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_dut_reg (
    .i_clock(clk), .i_reset(a_reset), .i_push(a_push), .i_din(a_din), .i_pop(a_pop),
    .o_dout(a_dout), .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_af),
    .o_almost_empty(a_ae), .o_count(a_count), .o_overflow(a_ovf), .o_underflow(a_unf)
  );

  fifo_flex #(.WIDTH(32), .DEPTH(D1), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_dut_fwft (
    .i_clock(clk), .i_reset(b_reset), .i_push(b_push), .i_din(b_din), .i_pop(b_pop),
    .o_dout(b_dout), .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_af),
    .o_almost_empty(b_ae), .o_count(b_count), .o_overflow(b_ovf), .o_underflow(b_unf)
  );

  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] din;
    int          exp_count;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t        tbl[36];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_count = 0;
  logic [31:0] sb[$];
  logic [31:0] last_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the registered-read FIFO and compare against the scoreboard.
  task automatic apply_a(input logic push, input logic pop, input logic [31:0] din, input string tag);
    logic acc_push, acc_pop;
    acc_push = push && (m_count < D0);
    acc_pop  = pop && (m_count > 0);
    if (acc_pop)  last_dout = sb.pop_front();
    if (acc_push) sb.push_back(din);
    m_count = m_count + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
    a_push = push; a_pop = pop; a_din = din;
    step();
    a_push = 1'b0; a_pop = 1'b0;
    check({tag, " count"}, 32'(a_count), 32'(m_count));
    check({tag, " full"},  32'(a_full),  32'(m_count == D0));
    check({tag, " empty"}, 32'(a_empty), 32'(m_count == 0));
    check({tag, " af"},    32'(a_af),    32'(m_count >= 14));
    check({tag, " ae"},    32'(a_ae),    32'(m_count <= 2));
    check({tag, " dout"},  a_dout,       last_dout);
  endtask

  initial begin
    a_reset = 1'b1; a_push = 1'b0; a_pop = 1'b0; a_din = '0;
    b_reset = 1'b1; b_push = 1'b0; b_pop = 1'b0; b_din = '0;
    step(); step();
    a_reset = 1'b0; b_reset = 1'b0;
    step();

    check("rst count", 32'(a_count), 32'd0);
    check("rst empty", 32'(a_empty), 32'd1);
    check("rst full",  32'(a_full),  32'd0);
    check("rst ae",    32'(a_ae),    32'd1);
    check("rst af",    32'(a_af),    32'd0);
    check("rst dout",  a_dout,       32'd0);
    check("rst ovf",   32'(a_ovf),   32'd0);
    check("rst unf",   32'(a_unf),   32'd0);
    check("rst fwft dout", b_dout,   32'd0);

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b0, $urandom, i + 1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 16, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'h0, 16, 1'b0, 1'b0};
    for (int i = 18; i < 34; i++) tbl[i] = '{1'b0, 1'b1, 32'h0, 33 - i, 1'b0, 1'b0};
    tbl[34] = '{1'b0, 1'b1, 32'h0, 0, 1'b0, 1'b1};
    tbl[35] = '{1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0};

    for (int i = 0; i < 36; i++) begin
      apply_a(tbl[i].push, tbl[i].pop, tbl[i].din, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tcount", i), 32'(a_count), 32'(tbl[i].exp_count));
      check($sformatf("vec%0d ovf", i),    32'(a_ovf),   32'(tbl[i].exp_ovf));
      check($sformatf("vec%0d unf", i),    32'(a_unf),   32'(tbl[i].exp_unf));
    end

    // Steady state at count 8 with simultaneous push/pop; pointers wrap.
    for (int i = 0; i < 8; i++)  apply_a(1'b1, 1'b0, $urandom, $sformatf("fill%0d", i));
    for (int i = 0; i < 20; i++) apply_a(1'b1, 1'b1, $urandom, $sformatf("both%0d", i));
    check("both count8", 32'(a_count), 32'd8);
    for (int i = 0; i < 8; i++)  apply_a(1'b0, 1'b1, 32'h0, $sformatf("drain%0d", i));

    // Reset mid-stream while a push is presented.
    for (int i = 0; i < 5; i++) apply_a(1'b1, 1'b0, $urandom, $sformatf("pre%0d", i));
    check("pre rst count", 32'(a_count), 32'd5);
    a_reset = 1'b1; a_push = 1'b1; a_din = 32'h0000_0077;
    step();
    a_reset = 1'b0; a_push = 1'b0;
    check("midrst count", 32'(a_count), 32'd0);
    check("midrst empty", 32'(a_empty), 32'd1);
    check("midrst dout",  a_dout,       32'd0);
    m_count = 0; sb.delete(); last_dout = '0;
    apply_a(1'b0, 1'b0, 32'h0, "post rst idle");
    apply_a(1'b1, 1'b0, 32'h1357_9BDF, "post rst push");
    apply_a(1'b0, 1'b1, 32'h0, "post rst pop");

    // FWFT build.
    b_push = 1'b1; b_din = 32'hA5A5_0001;
    step();
    b_push = 1'b0;
    check("fwft first dout",  b_dout,        32'hA5A5_0001);
    check("fwft first empty", 32'(b_empty),  32'd0);
    check("fwft first count", 32'(b_count),  32'd1);
    step();
    check("fwft hold dout",   b_dout,        32'hA5A5_0001);
    b_push = 1'b1; b_din = 32'h00C0_FFEE;
    step();
    b_push = 1'b0;
    check("fwft 2nd push dout", b_dout,      32'hA5A5_0001);
    b_pop = 1'b1;
    step();
    check("fwft pop1 dout",   b_dout,        32'h00C0_FFEE);
    step();
    b_pop = 1'b0;
    check("fwft pop2 dout",   b_dout,        32'd0);
    check("fwft pop2 empty",  32'(b_empty),  32'd1);
    b_pop = 1'b1;
    step();
    b_pop = 1'b0;
    check("fwft unf",         32'(b_unf),    32'd1);
    check("fwft unf dout",    b_dout,        32'd0);
    step();
    check("fwft unf clear",   32'(b_unf),    32'd0);
    for (int i = 0; i < D1; i++) begin
      b_push = 1'b1; b_din = 32'h100 + 32'(i);
      step();
      check($sformatf("fwft fill%0d count", i), 32'(b_count), 32'(i + 1));
      check($sformatf("fwft fill%0d af", i),    32'(b_af),    32'(i + 1 >= 3));
      check($sformatf("fwft fill%0d ae", i),    32'(b_ae),    32'(i + 1 <= 1));
    end
    step();
    b_push = 1'b0;
    check("fwft ovf",       32'(b_ovf),   32'd1);
    check("fwft full",      32'(b_full),  32'd1);
    check("fwft full dout", b_dout,       32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
